guess_entry_ctrl: RTL and testbench

Sequencer between the debounced, edge-detected player keys and the guess checker in the Mastermind datapath. It consumes one-cycle key pulses (color cycle, next slot, submit) and builds a multi-slot color guess. It hands the finished guess to the checker with a valid/ready handshake, then waits for the exact-match score. It also tracks the turn count and declares win or lose.

---
 rtl/guess_entry_ctrl.sv | 118 +++++++++++
 tb/tb_guess_entry_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/guess_entry_ctrl.sv
// guess_entry_ctrl: builds a Mastermind guess from one-cycle key pulses,
// offers it to the checker over valid/ready, then scores the turn.
// Ports:
//   clk, Reset                      clock, sync active-high reset
//   colorPulse/nextPulse/submitPulse key pulses (priority submit>next>color)
//   guessReady                      checker accepts the offered guess
//   resultValid, exactCount         score pulse for the last guess
//   guess                           slot i color at [3i+2:3i]
//   slotSel                         slot being edited
//   guessValid                      guess offered to checker
//   turn                            completed guesses
//   busy                            guess in flight (offered or scoring)
//   win, lose                       sticky end-of-game flags
module guess_entry_ctrl #(
    parameter int NUM_SLOTS  = 4,
    parameter int NUM_COLORS = 6,
    parameter int MAX_TURNS  = 10
) (
    input  logic                   clk,
    input  logic                   Reset,
    input  logic                   colorPulse,
    input  logic                   nextPulse,
    input  logic                   submitPulse,
    input  logic                   guessReady,
    input  logic                   resultValid,
    input  logic [2:0]             exactCount,
    output logic [3*NUM_SLOTS-1:0] guess,
    output logic [1:0]             slotSel,
    output logic                   guessValid,
    output logic [3:0]             turn,
    output logic                   busy,
    output logic                   win,
    output logic                   lose
);

    typedef enum logic [1:0] {
        EDIT,
        SUBMIT,
        WAIT,
        DONE
    } state_t;

    state_t state;

    logic [3*NUM_SLOTS-1:0] bumped;
    logic [1:0]             slotNext;
    logic [3:0]             turnNext;
    logic [2:0]             cur;

    // Guess with the selected slot's color advanced (wraps to 0).
    always_comb begin
        bumped = guess;
        cur    = 3'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (int'(slotSel) == i) begin
                cur = guess[3*i +: 3];
                bumped[3*i +: 3] = (cur == 3'(NUM_COLORS - 1)) ?
                                   3'd0 : cur + 3'd1;
            end
        end
    end

    assign slotNext = (slotSel == 2'(NUM_SLOTS - 1)) ? 2'd0 : slotSel + 2'd1;
    assign turnNext = turn + 4'd1;

    always_ff @(posedge clk) begin
        if (Reset) begin
            state      <= EDIT;
            guess      <= '0;
            slotSel    <= 2'd0;
            guessValid <= 1'b0;
            turn       <= 4'd0;
            busy       <= 1'b0;
            win        <= 1'b0;
            lose       <= 1'b0;
        end else begin
            unique case (state)
                EDIT: begin
                    if (submitPulse) begin
                        state      <= SUBMIT;
                        guessValid <= 1'b1;
                        busy       <= 1'b1;
                    end else if (nextPulse) begin
                        slotSel <= slotNext;
                    end else if (colorPulse) begin
                        guess <= bumped;
                    end
                end
                SUBMIT: begin
                    if (guessReady) begin
                        guessValid <= 1'b0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (resultValid) begin
                        turn <= turnNext;
                        busy <= 1'b0;
                        // exactCount above NUM_SLOTS falls through as a miss
                        if (exactCount == 3'(NUM_SLOTS)) begin
                            win   <= 1'b1;
                            state <= DONE;
                        end else if (turnNext == 4'(MAX_TURNS)) begin
                            lose  <= 1'b1;
                            state <= DONE;
                        end else begin
                            slotSel <= 2'd0;
                            state   <= EDIT;
                        end
                    end
                end
                DONE: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_guess_entry_ctrl.sv
// tb_guess_entry_ctrl: directed scenarios plus random pulses, compared
// every cycle against a game-level model of guess_entry_ctrl.
module tb_guess_entry_ctrl;

    localparam int NS = 4;
    localparam int NC = 6;
    localparam int MT = 10;

    logic          clk = 1'b0;
    logic          Reset, colorPulse, nextPulse, submitPulse;
    logic          guessReady, resultValid;
    logic [2:0]    exactCount;
    logic [3*NS-1:0] guess;
    logic [1:0]    slotSel;
    logic          guessValid, busy, win, lose;
    logic [3:0]    turn;

    int n_chk = 0;
    int n_err = 0;

    // game-level model
    int  colors [NS];
    int  m_slot, m_turn;
    bit  m_offered, m_scoring, m_win, m_lose;

    guess_entry_ctrl #(
        .NUM_SLOTS(NS), .NUM_COLORS(NC), .MAX_TURNS(MT)
    ) dut (
        .clk(clk), .Reset(Reset),
        .colorPulse(colorPulse), .nextPulse(nextPulse),
        .submitPulse(submitPulse), .guessReady(guessReady),
        .resultValid(resultValid), .exactCount(exactCount),
        .guess(guess), .slotSel(slotSel), .guessValid(guessValid),
        .turn(turn), .busy(busy), .win(win), .lose(lose)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3*NS-1:0] packed_guess();
        logic [3*NS-1:0] g = '0;
        for (int i = 0; i < NS; i++) g[3*i +: 3] = 3'(colors[i]);
        return g;
    endfunction

    task automatic model_step(bit rst, bit cp, bit np, bit sp, bit gr,
                              bit rv, int ec);
        if (rst) begin
            foreach (colors[i]) colors[i] = 0;
            m_slot = 0; m_turn = 0;
            m_offered = 0; m_scoring = 0; m_win = 0; m_lose = 0;
        end else if (m_win || m_lose) begin
            // game over: frozen
        end else if (m_offered) begin
            if (gr) begin m_offered = 0; m_scoring = 1; end
        end else if (m_scoring) begin
            if (rv) begin
                m_scoring = 0;
                m_turn++;
                if (ec == NS) m_win = 1;
                else if (m_turn == MT) m_lose = 1;
                else m_slot = 0;
            end
        end else begin
            if (sp) m_offered = 1;
            else if (np) m_slot = (m_slot + 1) % NS;
            else if (cp) colors[m_slot] = (colors[m_slot] + 1) % NC;
        end
    endtask

    task automatic cycle(bit rst, bit cp, bit np, bit sp, bit gr,
                         bit rv, int ec);
        Reset = rst; colorPulse = cp; nextPulse = np; submitPulse = sp;
        guessReady = gr; resultValid = rv; exactCount = 3'(ec);
        @(posedge clk);
        model_step(rst, cp, np, sp, gr, rv, ec);
        @(negedge clk);
        check("guess", 32'(guess), 32'(packed_guess()));
        check("slotSel", 32'(slotSel), 32'(m_slot));
        check("guessValid", 32'(guessValid), 32'(m_offered));
        check("turn", 32'(turn), 32'(m_turn));
        check("busy", 32'(busy), 32'(m_offered | m_scoring));
        check("win", 32'(win), 32'(m_win));
        check("lose", 32'(lose), 32'(m_lose));
        check("win_lose_excl", 32'(win & lose), 32'd0);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        Reset = 1; colorPulse = 0; nextPulse = 0; submitPulse = 0;
        guessReady = 0; resultValid = 0; exactCount = 0;
        model_step(1, 0, 0, 0, 0, 0, 0);

        // reset then color edits
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        check("rst_guess", 32'(guess), 32'd0);
        for (int i = 0; i < 7; i++) cycle(0, 1, 0, 0, 0, 0, 0);
        check("slot0_wrap", 32'(guess[2:0]), 32'd1);
        cycle(0, 0, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0);
        check("tp_guess", 32'(guess), 32'h011);
        check("tp_slot", 32'(slotSel), 32'd1);

        // slot wrap and priority
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, 0, 0, 0);
        check("slot_wrap", 32'(slotSel), 32'd1);
        cycle(0, 0, 1, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0, 0);
        check("slot_zero", 32'(slotSel), 32'd0);
        cycle(0, 1, 1, 0, 0, 0, 0);
        check("next_over_color", 32'(guess), 32'h011);
        cycle(0, 1, 0, 1, 0, 0, 0);
        check("submit_over_color", 32'(guess), 32'h011);

        // handshake stall with ignored color pulses
        for (int i = 0; i < 5; i++) cycle(0, 1, 1, 1, 0, 1, 4);
        check("stall_valid", 32'(guessValid), 32'd1);
        check("stall_guess", 32'(guess), 32'h011);
        cycle(0, 0, 0, 0, 1, 1, 4);
        check("hs_valid", 32'(guessValid), 32'd0);
        check("hs_busy", 32'(busy), 32'd1);
        check("hs_rv_ignored", 32'(win), 32'd0);

        // win
        cycle(0, 0, 0, 0, 0, 1, 4);
        check("win_turn", 32'(turn), 32'd1);
        check("win_flag", 32'(win), 32'd1);
        for (int i = 0; i < 6; i++) cycle(0, 1, 1, 1, 1, 1, 2);

        // lose
        cycle(1, 0, 0, 0, 0, 0, 0);
        for (int r = 0; r < MT; r++) begin
            cycle(0, 1, 0, 0, 0, 0, 0);
            cycle(0, 0, 0, 1, 0, 0, 0);
            cycle(0, 0, 0, 0, 1, 0, 0);
            cycle(0, 0, 0, 0, 0, 1, 2);
            if (r < MT - 1) check("round_slot", 32'(slotSel), 32'd0);
        end
        check("lose_flag", 32'(lose), 32'd1);
        check("lose_turn", 32'(turn), 32'(MT));
        check("lose_nowin", 32'(win), 32'd0);
        idle(3);

        // reset mid-handshake, stray result in EDIT
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 1, 0, 0);
        check("midrst_valid", 32'(guessValid), 32'd0);
        check("midrst_guess", 32'(guess), 32'd0);
        cycle(0, 0, 0, 0, 0, 1, 1);
        check("stray_rv", 32'(turn), 32'd0);

        // random play
        for (int i = 0; i < 4000; i++) begin
            bit rst = ($urandom_range(0, 299) == 0);
            bit cp  = ($urandom_range(0, 2) == 0);
            bit np  = ($urandom_range(0, 3) == 0);
            bit sp  = ($urandom_range(0, 5) == 0);
            bit gr  = ($urandom_range(0, 1) == 0);
            bit rv  = ($urandom_range(0, 3) == 0);
            int ec  = ($urandom_range(0, 9) == 0) ? NS :
                      int'($urandom_range(0, 7));
            cycle(rst, cp, np, sp, gr, rv, ec);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
